// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and scan-code receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StShift,
      StAck,
      StWaitIdle,
      StErr
   } ps2_tx_state_e;

   localparam logic [3:0] ACK_FALL  = 4'd11;
   localparam logic [3:0] STOP_FALL = 4'd10;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   function automatic int unsigned cycles_per_us(input int unsigned freq_hz);
      return freq_hz / 1_000_000;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 line (idle level high).
module ps2_sync_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic line_i,
   output logic sync_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= line_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, device-clocked shift-out,
// ACK check and timeouts. Lines are open-drain; *_oe_o = 1 pulls the line low.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
   parameter int unsigned INHIBIT_US       = 100,
   parameter int unsigned START_TIMEOUT_US = 15000,
   parameter int unsigned BIT_TIMEOUT_US   = 2000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_data_oe_o,
   output logic       busy_o,
   output logic       tx_done_o,
   output logic       tx_err_o
);

   localparam int unsigned CycPerUs   = cycles_per_us(CLK_FREQ_HZ);
   localparam int unsigned InhibitCyc = INHIBIT_US * CycPerUs;
   localparam int unsigned StartCyc   = START_TIMEOUT_US * CycPerUs;
   localparam int unsigned BitCyc     = BIT_TIMEOUT_US * CycPerUs;
   localparam int unsigned TimerW     = $clog2(StartCyc) + 1;

   localparam logic [TimerW-1:0] InhibitLast = TimerW'(InhibitCyc - 1);
   localparam logic [TimerW-1:0] InhibitData = TimerW'(InhibitCyc - 2);
   localparam logic [TimerW-1:0] StartLast   = TimerW'(StartCyc - 1);
   localparam logic [TimerW-1:0] BitLast     = TimerW'(BitCyc - 1);

   ps2_tx_state_e     state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d, bit_cnt_inc;
   logic [7:0]        data_q, data_d;
   logic              parity_q, parity_d;
   logic              clk_oe_q, clk_oe_d;
   logic              data_oe_q, data_oe_d;
   logic              done_q, done_d;
   logic              clk_sync, clk_fall, data_sync, data_fall;

   ps2_sync_edge u_sync_clk (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .line_i (ps2_clk_i),
      .sync_o (clk_sync),
      .fall_o (clk_fall)
   );

   ps2_sync_edge u_sync_data (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .line_i (ps2_data_i),
      .sync_o (data_sync),
      .fall_o (data_fall)
   );

   assign bit_cnt_inc = (bit_cnt_q == 4'hF) ? bit_cnt_q : bit_cnt_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 1'b1;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      parity_d  = parity_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            timer_d   = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (tx_valid_i) begin
               data_d   = tx_data_i;
               parity_d = ~^tx_data_i;
               clk_oe_d = 1'b1;
               state_d  = StInhibit;
            end
         end
         StInhibit: begin
            // Start bit goes low one cycle before the clock is released.
            if (timer_q == InhibitData) data_oe_d = 1'b1;
            if (timer_q == InhibitLast) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               timer_d   = '0;
               bit_cnt_d = '0;
               state_d   = StReq;
            end
         end
         StReq: begin
            if (clk_fall) begin
               data_oe_d = ~data_q[0];
               bit_cnt_d = 4'd1;
               timer_d   = '0;
               state_d   = StShift;
            end else if (timer_q == StartLast) begin
               state_d = StErr;
            end
         end
         StShift: begin
            if (clk_fall) begin
               timer_d   = '0;
               bit_cnt_d = bit_cnt_inc;
               if (bit_cnt_q < 4'd8)       data_oe_d = ~data_q[bit_cnt_q[2:0]];
               else if (bit_cnt_q == 4'd8) data_oe_d = ~parity_q;
               else                        data_oe_d = 1'b0;
               if (bit_cnt_inc == STOP_FALL) state_d = StAck;
            end else if (timer_q == BitLast) begin
               state_d = StErr;
            end
         end
         StAck: begin
            if (clk_fall) begin
               timer_d   = '0;
               bit_cnt_d = bit_cnt_inc;
               state_d   = data_sync ? StErr : StWaitIdle;
            end else if (timer_q == BitLast) begin
               state_d = StErr;
            end
         end
         StWaitIdle: begin
            if (clk_sync && data_sync) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else if (timer_q == BitLast) begin
               state_d = StErr;
            end
         end
         StErr: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (state_d == StErr) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         parity_q  <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         parity_q  <= parity_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         done_q    <= done_d;
      end
   end

   // Data falls are not needed by the transmitter; the receiver uses them.
   logic unused_data_fall;
   assign unused_data_fall = data_fall;

   assign tx_ready_o    = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign ps2_clk_oe_o  = clk_oe_q;
   assign ps2_data_oe_o = data_oe_q;
   assign tx_done_o     = done_q;
   assign tx_err_o      = (state_q == StErr);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural keyboard clocking at 12.5 kHz.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   // 1 MHz system clock keeps the frame and timeouts short in cycles.
   localparam int unsigned FreqHz  = 1_000_000;
   localparam int unsigned InhUs   = 100;
   localparam int unsigned StartUs = 15000;
   localparam int unsigned BitUs   = 2000;
   localparam int InhCyc   = InhUs * (FreqHz / 1_000_000);
   localparam int StartCyc = StartUs * (FreqHz / 1_000_000);
   localparam int BitCyc   = BitUs * (FreqHz / 1_000_000);
   localparam int Half     = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, clk_oe, data_oe, busy, tx_done, tx_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
   assign ps2_data_line = ~(data_oe | dev_data_low);

   ps2_host_tx #(
      .CLK_FREQ_HZ      (FreqHz),
      .INHIBIT_US       (InhUs),
      .START_TIMEOUT_US (StartUs),
      .BIT_TIMEOUT_US   (BitUs)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .tx_data_i     (tx_data),
      .tx_valid_i    (tx_valid),
      .tx_ready_o    (tx_ready),
      .ps2_clk_i     (ps2_clk_line),
      .ps2_data_i    (ps2_data_line),
      .ps2_clk_oe_o  (clk_oe),
      .ps2_data_oe_o (data_oe),
      .busy_o        (busy),
      .tx_done_o     (tx_done),
      .tx_err_o      (tx_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err)  err_cnt  <= err_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected bits on device rising edges 1..10: data LSB first, odd parity, stop.
   function automatic logic [9:0] frame_bits(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return {1'b1, ((ones % 2) == 0), b};
   endfunction

   task automatic host_start(input logic [7:0] b, input bit inject, output int rel);
      int n = 0;
      @(negedge clk);
      check_eq("ready_idle", 32'(tx_ready), 1);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check_eq("ready_drop", 32'(tx_ready), 0);
      check_eq("busy_set", 32'(busy), 1);
      while (clk_oe && n < InhCyc + 10) begin
         n++;
         tx_valid = inject && (n == 5);
         if (tx_valid) tx_data = 8'h55;
         @(negedge clk);
      end
      tx_valid = 1'b0;
      check_eq("inhibit_len", 32'(n), 32'(InhCyc));
      check_eq("start_bit", 32'(data_oe), 1);
      rel = cyc;
   endtask

   task automatic dev_clock(input int nfalls, input bit ack, output logic [9:0] bits,
                            output int last_fall);
      bits = '0;
      last_fall = 0;
      for (int i = 1; i <= nfalls; i++) begin
         repeat (Half) @(negedge clk);
         dev_clk_low = 1'b1;
         last_fall = cyc;
         repeat (Half) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i <= 10) bits[i-1] = ps2_data_line;
         if (i == 10 && ack) dev_data_low = 1'b1;
         if (i == 11) dev_data_low = 1'b0;
      end
   endtask

   task automatic wait_pulse(input string tag, input bit want_done, input int limit,
                             output int at);
      bit seen = 1'b0;
      at = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (want_done ? tx_done : tx_err) begin
            seen = 1'b1;
            at = cyc;
            break;
         end
      end
      check_eq(tag, 32'(seen), 1);
   endtask

   task automatic send_ok(input logic [7:0] b, input bit inject, output logic [9:0] bits);
      int rel, lf, at, d0, e0;
      bit stayed;
      d0 = done_cnt;
      e0 = err_cnt;
      host_start(b, inject, rel);
      dev_clock(11, 1'b1, bits, lf);
      check_eq("frame_bits", 32'(bits), 32'(frame_bits(b)));
      wait_pulse("done_pulse", 1'b1, 4 * Half, at);
      check_eq("ready_at_done", 32'(tx_ready), 1);
      check_eq("busy_at_done", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check_eq("done_once", 32'(done_cnt - d0), 1);
      check_eq("no_err", 32'(err_cnt - e0), 0);
      if (inject) begin
         stayed = 1'b0;
         repeat (200) begin
            @(negedge clk);
            stayed |= busy;
         end
         check_eq("ignored_valid", 32'(stayed), 0);
      end
   endtask

   initial begin
      logic [9:0] bits;
      int rel, lf, at, d0, e0, d;

      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(tx_ready), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_clk_oe", 32'(clk_oe), 0);
      check_eq("rst_data_oe", 32'(data_oe), 0);
      check_eq("rst_done", 32'(tx_done), 0);
      check_eq("rst_err", 32'(tx_err), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      send_ok(CMD_SET_LED, 1'b0, bits);
      check_eq("ed_literal", 32'(bits), 32'h3ED);
      send_ok(8'h07, 1'b0, bits);
      check_eq("parity_07", 32'(bits[8]), 0);
      send_ok(8'h00, 1'b0, bits);
      check_eq("parity_00", 32'(bits[8]), 1);
      repeat (5) send_ok(8'($urandom_range(0, 255)), 1'b0, bits);

      // Device never clocks.
      host_start(CMD_RESET, 1'b0, rel);
      wait_pulse("start_to_pulse", 1'b0, StartCyc + 20, at);
      check_eq("start_to_time", 32'(at - rel), 32'(StartCyc));
      @(negedge clk);
      check_eq("start_to_clk_oe", 32'(clk_oe), 0);
      check_eq("start_to_data_oe", 32'(data_oe), 0);
      check_eq("start_to_ready", 32'(tx_ready), 1);

      // NACK: data left high at fall 11.
      d0 = done_cnt;
      e0 = err_cnt;
      host_start(CMD_ENABLE, 1'b0, rel);
      dev_clock(11, 1'b0, bits, lf);
      check_eq("nack_bits", 32'(bits), 32'(frame_bits(CMD_ENABLE)));
      repeat (5) @(negedge clk);
      check_eq("nack_err", 32'(err_cnt - e0), 1);
      check_eq("nack_no_done", 32'(done_cnt - d0), 0);
      check_eq("nack_clk_oe", 32'(clk_oe), 0);
      check_eq("nack_data_oe", 32'(data_oe), 0);

      // Device stops after fall 5.
      host_start(8'hA5, 1'b0, rel);
      dev_clock(5, 1'b1, bits, lf);
      wait_pulse("bit_to_pulse", 1'b0, BitCyc + 60, at);
      d = at - lf;
      check_eq("bit_to_time", 32'(d >= BitCyc && d <= BitCyc + 4), 1);
      @(negedge clk);
      check_eq("bit_to_released", 32'(clk_oe | data_oe), 0);

      // Reset mid-shift.
      host_start(CMD_SET_LED, 1'b0, rel);
      dev_clock(4, 1'b1, bits, lf);
      repeat (10) @(negedge clk);
      check_eq("pre_rst_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_clk_oe", 32'(clk_oe), 0);
      check_eq("rst_mid_data_oe", 32'(data_oe), 0);
      check_eq("rst_mid_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_ok(CMD_ENABLE, 1'b0, bits);

      // tx_valid with 0x55 while busy is dropped.
      send_ok(8'hA3, 1'b1, bits);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
